// File: rtl/hs1way_arbiter_pkg.sv
// Shared helpers for the hs1way round-robin arbiter: width functions and the source index type.
package hs1way_arbiter_pkg;

    localparam int c_max_inputs = 16;
    localparam int c_max_src_w  = 4;

    typedef logic [c_max_src_w-1:0] t_src_idx;

    function automatic int f_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int f_ptr_width(input int depth);
        return f_clog2(depth);
    endfunction

    function automatic int f_occ_width(input int depth);
        return f_clog2(depth) + 1;
    endfunction

    // Round-robin successor; explicit wrap because the input count need not be a power of 2.
    function automatic t_src_idx f_next_src(input t_src_idx current, input int nb_inputs);
        t_src_idx next;
        if (int'(current) >= nb_inputs - 1) begin
            next = '0;
        end else begin
            next = current + t_src_idx'(1);
        end
        return next;
    endfunction

endpackage

// File: rtl/hs1way_fifo.sv
// Show-ahead register FIFO absorbing one hs1way input; a pop of a full FIFO frees the
// slot for a push arriving in the same cycle.
module hs1way_fifo
    import hs1way_arbiter_pkg::*;
#(
    parameter int g_data_size  = 8,
    parameter int g_fifo_depth = 4
) (
    input  logic                   p_clock,
    input  logic                   p_reset,
    input  logic                   p_push,
    input  logic [g_data_size-1:0] p_data,
    input  logic                   p_pop,
    output logic [g_data_size-1:0] p_head,
    output logic                   p_empty,
    output logic                   p_full
);

    localparam int c_ptr_w = f_ptr_width(g_fifo_depth);
    localparam int c_occ_w = f_occ_width(g_fifo_depth);
    localparam logic [c_occ_w-1:0] c_depth = c_occ_w'(g_fifo_depth);

    logic [g_data_size-1:0] mem_q [g_fifo_depth];
    logic [g_data_size-1:0] mem_d [g_fifo_depth];
    logic [c_ptr_w-1:0]     wr_ptr_q;
    logic [c_ptr_w-1:0]     wr_ptr_d;
    logic [c_ptr_w-1:0]     rd_ptr_q;
    logic [c_ptr_w-1:0]     rd_ptr_d;
    logic [c_occ_w-1:0]     occ_q;
    logic [c_occ_w-1:0]     occ_d;
    logic                   do_push;
    logic                   do_pop;

    assign p_empty = (occ_q == '0);
    assign p_full  = (occ_q == c_depth);
    assign p_head  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = p_pop && !p_empty;
        do_push  = p_push && (!p_full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = p_data;
            wr_ptr_d        = wr_ptr_q + c_ptr_w'(1);
        end

        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
        end

        if (do_push && !do_pop) begin
            occ_d = occ_q + c_occ_w'(1);
        end else if (do_pop && !do_push) begin
            occ_d = occ_q - c_occ_w'(1);
        end
    end

    // Storage needs no reset: only the occupancy decides what is readable.
    always_ff @(posedge p_clock) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge p_clock or posedge p_reset) begin
        if (p_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule

// File: rtl/hs1way_rr_arbiter.sv
// Merges several non-stallable hs1way streams onto one output: per-input FIFOs drained
// by a round-robin scheduler, one word per cycle, with sticky per-input drop flags.
module hs1way_rr_arbiter
    import hs1way_arbiter_pkg::*;
#(
    parameter int g_data_size  = 8,
    parameter int g_nb_inputs  = 4,
    parameter int g_fifo_depth = 4
) (
    input  logic                                 p_clock,
    input  logic                                 p_reset,
    input  logic [g_nb_inputs-1:0]               p_in_push,
    input  logic [g_nb_inputs*g_data_size-1:0]   p_in_data,
    output logic                                 p_out_push,
    output logic [g_data_size-1:0]               p_out_data,
    output logic [f_clog2(g_nb_inputs)-1:0]      p_out_source,
    output logic [g_nb_inputs-1:0]               p_overflow,
    input  logic [g_nb_inputs-1:0]               p_clear_overflow
);

    localparam int c_src_w = f_clog2(g_nb_inputs);

    logic [g_nb_inputs-1:0]                  fifo_empty;
    logic [g_nb_inputs-1:0]                  fifo_full;
    logic [g_nb_inputs-1:0]                  fifo_pop;
    logic [g_nb_inputs-1:0][g_data_size-1:0] fifo_head;

    logic [g_nb_inputs-1:0] grant_oh;
    logic                   grant_valid;
    logic [c_src_w-1:0]     grant_idx;
    logic [g_data_size-1:0] grant_data;
    logic [g_nb_inputs-1:0] drop;

    logic                   out_push_q;
    logic                   out_push_d;
    logic [g_data_size-1:0] out_data_q;
    logic [g_data_size-1:0] out_data_d;
    logic [c_src_w-1:0]     out_source_q;
    logic [c_src_w-1:0]     out_source_d;
    logic [c_src_w-1:0]     rr_ptr_q;
    logic [c_src_w-1:0]     rr_ptr_d;
    logic [g_nb_inputs-1:0] overflow_q;
    logic [g_nb_inputs-1:0] overflow_d;

    for (genvar i = 0; i < g_nb_inputs; i++) begin : g_fifo
        hs1way_fifo #(
            .g_data_size  (g_data_size),
            .g_fifo_depth (g_fifo_depth)
        ) u_fifo (
            .p_clock (p_clock),
            .p_reset (p_reset),
            .p_push  (p_in_push[i]),
            .p_data  (p_in_data[i*g_data_size +: g_data_size]),
            .p_pop   (fifo_pop[i]),
            .p_head  (fifo_head[i]),
            .p_empty (fifo_empty[i]),
            .p_full  (fifo_full[i])
        );
    end

    // Two passes give the wrap-around search: first at/after rr_ptr, then from input 0.
    always_comb begin
        grant_valid = 1'b0;
        grant_oh    = '0;
        for (int i = 0; i < g_nb_inputs; i++) begin
            if (!grant_valid && !fifo_empty[i] && (i >= int'(rr_ptr_q))) begin
                grant_valid = 1'b1;
                grant_oh[i] = 1'b1;
            end
        end
        for (int i = 0; i < g_nb_inputs; i++) begin
            if (!grant_valid && !fifo_empty[i]) begin
                grant_valid = 1'b1;
                grant_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        grant_idx  = '0;
        grant_data = '0;
        for (int i = 0; i < g_nb_inputs; i++) begin
            if (grant_oh[i]) begin
                grant_idx  = c_src_w'(i);
                grant_data = fifo_head[i];
            end
        end
    end

    assign fifo_pop = grant_oh;

    // A full FIFO popped this cycle accepts the push, so only unpopped full inputs drop.
    always_comb begin
        out_push_d   = grant_valid;
        out_data_d   = out_data_q;
        out_source_d = out_source_q;
        rr_ptr_d     = rr_ptr_q;

        if (grant_valid) begin
            out_data_d   = grant_data;
            out_source_d = grant_idx;
            rr_ptr_d     = c_src_w'(f_next_src(t_src_idx'(grant_idx), g_nb_inputs));
        end

        drop       = p_in_push & fifo_full & ~fifo_pop;
        overflow_d = (overflow_q & ~p_clear_overflow) | drop;
    end

    always_ff @(posedge p_clock or posedge p_reset) begin
        if (p_reset) begin
            out_push_q   <= 1'b0;
            out_data_q   <= '0;
            out_source_q <= '0;
            rr_ptr_q     <= '0;
            overflow_q   <= '0;
        end else begin
            out_push_q   <= out_push_d;
            out_data_q   <= out_data_d;
            out_source_q <= out_source_d;
            rr_ptr_q     <= rr_ptr_d;
            overflow_q   <= overflow_d;
        end
    end

    assign p_out_push   = out_push_q;
    assign p_out_data   = out_data_q;
    assign p_out_source = out_source_q;
    assign p_overflow   = overflow_q;

endmodule

// File: tb/tb_hs1way_rr_arbiter.sv
// Scoreboard bench for hs1way_rr_arbiter: a queue-based reference model predicts every
// output word, its source and its cycle, plus the sticky overflow flags.
module tb_hs1way_rr_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int SW = 2;

    typedef struct {
        int due;
        int data;
        int src;
    } exp_t;

    logic           clock;
    logic           reset;
    logic [N-1:0]   in_push;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   clear_ovf;
    logic           out_push;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_source;
    logic [N-1:0]   overflow;

    int total = 0;
    int bad = 0;
    int edge_cnt = 0;

    int mq [N][$];
    int m_ptr;
    logic [N-1:0] m_ovf;
    int m_drops [N];
    int m_grants;
    int full_pop_push = 0;
    exp_t sb [$];
    exp_t mon_e;

    int dut_outs;
    int dut_cnt [N];
    int out_log [$];
    int out_edge_log [$];

    hs1way_rr_arbiter #(
        .g_data_size  (W),
        .g_nb_inputs  (N),
        .g_fifo_depth (D)
    ) dut (
        .p_clock          (clock),
        .p_reset          (reset),
        .p_in_push        (in_push),
        .p_in_data        (in_data),
        .p_out_push       (out_push),
        .p_out_data       (out_data),
        .p_out_source     (out_source),
        .p_overflow       (overflow),
        .p_clear_overflow (clear_ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at edge %0d", name, actual, expected, edge_cnt);
        end
    endtask

    function automatic int modelNextGrant();
        int j;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (mq[j].size() > 0) return j;
        end
        return -1;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            mq[i].delete();
            m_drops[i] = 0;
            dut_cnt[i] = 0;
        end
        sb.delete();
        m_ptr = 0;
        m_ovf = '0;
        m_grants = 0;
        dut_outs = 0;
    endtask

    // One cycle of the arbiter's rules: serve the first non-empty queue from the pointer, then
    // accept pushes into queues with room (a pop this cycle makes room), otherwise drop.
    task automatic modelStep();
        int g;
        bit dropped;
        exp_t e;
        g = modelNextGrant();
        if (g >= 0) begin
            e.due = edge_cnt + 1;
            e.data = mq[g].pop_front();
            e.src = g;
            sb.push_back(e);
            m_ptr = (g + 1) % N;
            m_grants++;
            if (in_push[g] && mq[g].size() == D - 1) full_pop_push++;
        end
        for (int i = 0; i < N; i++) begin
            dropped = 1'b0;
            if (in_push[i]) begin
                if (mq[i].size() < D) begin
                    mq[i].push_back(int'(in_data[i*W +: W]));
                end else begin
                    dropped = 1'b1;
                    m_drops[i]++;
                end
            end
            m_ovf[i] = (m_ovf[i] && !clear_ovf[i]) || dropped;
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] push, input logic [N*W-1:0] data, input logic [N-1:0] clr);
        @(negedge clock);
        #1;
        in_push = push;
        in_data = data;
        clear_ovf = clr;
        modelStep();
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) applyStimulus('0, '0, '0);
    endtask

    task automatic resetDut();
        @(negedge clock);
        #1;
        reset = 1'b1;
        in_push = '0;
        in_data = '0;
        clear_ovf = '0;
        modelReset();
        repeat (2) @(negedge clock);
        #1 reset = 1'b0;
    endtask

    function automatic logic [N*W-1:0] wordAt(input int idx, input logic [W-1:0] value);
        logic [N*W-1:0] v;
        v = '0;
        v[idx*W +: W] = value;
        return v;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a word.
    always @(negedge clock) begin
        if (!reset) begin
            if (out_push) begin
                dut_outs++;
                dut_cnt[out_source]++;
                out_log.push_back(int'(out_source) * 256 + int'(out_data));
                out_edge_log.push_back(edge_cnt);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_out actual=src%0d/0x%0h expected=none", out_source, out_data);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("out_data", int'(out_data), mon_e.data);
                    checkOutput("out_source", int'(out_source), mon_e.src);
                    checkOutput("out_edge", edge_cnt, mon_e.due);
                end
            end else if (sb.size() > 0 && sb[0].due <= edge_cnt) begin
                total++;
                bad++;
                $display("[TB] FAIL missing_out actual=no push expected=src%0d/0x%0h", sb[0].src, sb[0].data);
                sb.delete(0);
            end
            checkOutput("overflow", int'(overflow), int'(m_ovf));
        end
    end

    initial begin : main
        logic [N-1:0] push;
        logic [N-1:0] clr;
        logic [N*W-1:0] data;
        int push_edge;
        int kept;
        int prev;
        int cmax;
        int cmin;
        bit cleared;
        int exp3a [4];
        int exp3b [4];

        reset = 1'b1;
        in_push = '0;
        in_data = '0;
        clear_ovf = '0;
        modelReset();
        repeat (2) @(negedge clock);
        #1;
        checkOutput("reset_push", int'(out_push), 0);
        checkOutput("reset_data", int'(out_data), 0);
        checkOutput("reset_source", int'(out_source), 0);
        checkOutput("reset_overflow", int'(overflow), 0);
        reset = 1'b0;

        // Test 1: asynchronous reset in the middle of a burst
        for (int c = 0; c < 6; c++) applyStimulus('1, $urandom, '0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        in_push = '0;
        in_data = '0;
        modelReset();
        #1;
        checkOutput("t1_rst_push", int'(out_push), 0);
        checkOutput("t1_rst_data", int'(out_data), 0);
        checkOutput("t1_rst_source", int'(out_source), 0);
        checkOutput("t1_rst_overflow", int'(overflow), 0);
        repeat (2) @(negedge clock);
        #1 reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus('0, '0, '0);
            checkOutput("t1_idle_push", int'(out_push), 0);
        end

        // Test 2: single input, three words, two-edge latency
        out_log.delete();
        out_edge_log.delete();
        push_edge = edge_cnt + 1;
        applyStimulus(4'b0100, wordAt(2, 8'h11), '0);
        applyStimulus(4'b0100, wordAt(2, 8'h22), '0);
        applyStimulus(4'b0100, wordAt(2, 8'h33), '0);
        idle(6);
        checkOutput("t2_count", out_log.size(), 3);
        if (out_log.size() >= 3) begin
            checkOutput("t2_w0", out_log[0], 2 * 256 + 'h11);
            checkOutput("t2_w1", out_log[1], 2 * 256 + 'h22);
            checkOutput("t2_w2", out_log[2], 2 * 256 + 'h33);
            checkOutput("t2_latency", out_edge_log[0], push_edge + 2);
        end

        // Test 3: round-robin order from pointer 0, then from pointer 2
        exp3a = '{0 * 256 + 'hA0, 1 * 256 + 'hA1, 2 * 256 + 'hA2, 3 * 256 + 'hA3};
        exp3b = '{2 * 256 + 'hA2, 3 * 256 + 'hA3, 0 * 256 + 'hA0, 1 * 256 + 'hA1};
        resetDut();
        out_log.delete();
        applyStimulus('1, 32'hA3A2A1A0, '0);
        idle(8);
        checkOutput("t3a_count", out_log.size(), 4);
        for (int i = 0; i < 4 && i < out_log.size(); i++) checkOutput("t3a_word", out_log[i], exp3a[i]);
        applyStimulus(4'b0010, wordAt(1, 8'h55), '0);
        idle(4);
        out_log.delete();
        applyStimulus('1, 32'hA3A2A1A0, '0);
        idle(8);
        checkOutput("t3b_count", out_log.size(), 4);
        for (int i = 0; i < 4 && i < out_log.size(); i++) checkOutput("t3b_word", out_log[i], exp3b[i]);

        // Test 4: input 1 bursts 8 words while the others stay backlogged
        resetDut();
        for (int c = 0; c < 4; c++) applyStimulus(4'b1101, $urandom, '0);
        out_log.delete();
        for (int k = 0; k < 8; k++) begin
            data = $urandom;
            data[W +: W] = 8'(8'h10 + k);
            applyStimulus('1, data, '0);
        end
        idle(24);
        checkOutput("t4_overflow1", int'(overflow[1]), 1);
        kept = 0;
        prev = -1;
        for (int i = 0; i < out_log.size(); i++) begin
            if (out_log[i] / 256 == 1) begin
                checkOutput("t4_order", int'((out_log[i] % 256) > prev), 1);
                prev = out_log[i] % 256;
                kept++;
            end
        end
        checkOutput("t4_kept", kept, 8 - m_drops[1]);

        // Test 5: push into a full FIFO in its grant cycle; clear colliding with a drop
        applyStimulus('0, '0, '1);
        idle(20);
        checkOutput("t5_cleared", int'(overflow), 0);
        full_pop_push = 0;
        for (int c = 0; c < 24; c++) begin
            push = 4'b1110;
            if (mq[0].size() < D || modelNextGrant() == 0) push[0] = 1'b1;
            applyStimulus(push, $urandom, '0);
        end
        push = 4'b1110;
        if (mq[0].size() < D || modelNextGrant() == 0) push[0] = 1'b1;
        applyStimulus(push, $urandom, '0);
        checkOutput("t5_no_drop0", int'(overflow[0]), 0);
        checkOutput("t5_full_pop_push_seen", int'(full_pop_push > 0), 1);
        cleared = 1'b0;
        for (int c = 0; c < 8 && !cleared; c++) begin
            push = 4'b1110;
            if (mq[0].size() < D || modelNextGrant() == 0) push[0] = 1'b1;
            clr = '0;
            if (mq[1].size() == D && modelNextGrant() != 1) begin
                clr[1] = 1'b1;
                cleared = 1'b1;
            end
            applyStimulus(push, $urandom, clr);
        end
        applyStimulus('0, '0, '0);
        checkOutput("t5_clear_hit", int'(cleared), 1);
        checkOutput("t5_set_wins", int'(overflow[1]), 1);
        applyStimulus('0, '0, 4'b0010);
        applyStimulus('0, '0, '0);
        checkOutput("t5_clear_alone", int'(overflow[1]), 0);
        idle(20);

        // Random traffic with occasional clears
        for (int c = 0; c < 300; c++) begin
            clr = ($urandom_range(0, 19) == 0) ? 4'($urandom) : '0;
            applyStimulus(4'($urandom), $urandom, clr);
        end
        idle(24);

        // Test 6: fairness soak
        resetDut();
        for (int c = 0; c < 1000; c++) applyStimulus('1, $urandom, '0);
        cmax = dut_cnt[0];
        cmin = dut_cnt[0];
        for (int i = 1; i < N; i++) begin
            if (dut_cnt[i] > cmax) cmax = dut_cnt[i];
            if (dut_cnt[i] < cmin) cmin = dut_cnt[i];
        end
        checkOutput("t6_spread", cmax - cmin, (cmax - cmin <= 1) ? cmax - cmin : 1);
        idle(24);
        checkOutput("t6_total", dut_outs, m_grants);
        checkOutput("t6_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
